mul_issue: RTL and testbench

- Operand-side front end for the half-precision multiplier.
- Buffers incoming FP16 operand pairs in a small FIFO and issues them one at a time to the multi-cycle multiplier's start/done interface.
- Captures each product into a valid/ready output register, tagged with IEEE class flags.
- Sits directly upstream of the multiplier; a watchdog flags a multiplier that never answers.

---
 rtl/mul_issue.sv | 173 +++++++++++++++++
 tb/tb_mul_issue.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue.sv
// Operand front end for the FP16 multiplier: queues operand pairs, issues them one at a
// time over a start/done handshake, and registers each product with its IEEE class flags.
module mul_issue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 63
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [15:0]                in_a,
  input  logic [15:0]                in_b,
  output logic                       mul_start,
  output logic [15:0]                mul_a,
  output logic [15:0]                mul_b,
  input  logic [15:0]                mul_out,
  input  logic                       mul_done,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_data,
  output logic [3:0]                 out_flags,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy,
  output logic                       err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // {nan, inf, zero, subnormal}; all clear means a normal number
  function automatic logic [3:0] fp16_class(input logic [15:0] v);
    logic [4:0] e;
    logic [9:0] f;
    e = v[14:10];
    f = v[9:0];
    fp16_class = {(e == 5'd31) && (f != 10'd0),
                  (e == 5'd31) && (f == 10'd0),
                  (v[14:0] == 15'd0),
                  (e == 5'd0) && (f != 10'd0)};
  endfunction

  logic [31:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          in_ready_r;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   head_s;

  state_t        state_r;
  logic [WW-1:0] wdog_r;
  logic          mul_start_r;
  logic [15:0]   mul_a_r;
  logic [15:0]   mul_b_r;
  logic          out_valid_r;
  logic [15:0]   out_data_r;
  logic [3:0]    out_flags_r;
  logic          busy_r;
  logic          err_r;

  // Handshake decode and next occupancy
  always_comb begin
    push_s      = in_valid && in_ready_r;
    pop_s       = (state_r == S_IDLE) && (count_r != {CW{1'b0}}) && !out_valid_r;
    head_s      = mem_r[rd_ptr_r];
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Operand FIFO storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {32{1'b0}};
      end
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      in_ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {in_a, in_b};
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r    <= count_nxt_s;
      in_ready_r <= (count_nxt_s < CW'(DEPTH));
    end
  end

  // Issue FSM, watchdog and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      wdog_r      <= {WW{1'b0}};
      mul_start_r <= 1'b0;
      mul_a_r     <= 16'h0000;
      mul_b_r     <= 16'h0000;
      out_valid_r <= 1'b0;
      out_data_r  <= 16'h0000;
      out_flags_r <= 4'b0000;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      // A capture later in this block overrides the consume
      if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
      case (state_r)
        S_IDLE: begin
          if (pop_s) begin
            mul_start_r <= 1'b1;
            mul_a_r     <= head_s[31:16];
            mul_b_r     <= head_s[15:0];
            wdog_r      <= {WW{1'b0}};
            busy_r      <= 1'b1;
            state_r     <= S_WAIT;
          end else begin
            mul_start_r <= 1'b0;
          end
        end
        S_WAIT: begin
          mul_start_r <= 1'b0;
          if (mul_done) begin
            out_data_r  <= mul_out;
            out_flags_r <= fp16_class(mul_out);
            out_valid_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= S_IDLE;
          end else if (wdog_r == WW'(TIMEOUT - 1)) begin
            // Watchdog expires this edge: err rises TIMEOUT cycles after the start pulse
            err_r   <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            wdog_r <= wdog_r + WW'(1);
          end
        end
        default: begin
          mul_start_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign count     = count_r;
  assign mul_start = mul_start_r;
  assign mul_a     = mul_a_r;
  assign mul_b     = mul_b_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_flags = out_flags_r;
  assign busy      = busy_r;
  assign err       = err_r;

endmodule

// File: tb/tb_mul_issue.sv
// Self-checking bench for mul_issue: behavioural multiplier stub, queue scoreboard,
// directed scenarios followed by randomized traffic.
module tb_mul_issue;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 63;
  localparam int CW      = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid, in_ready;
  logic [15:0]   in_a, in_b;
  logic          mul_start, mul_done;
  logic [15:0]   mul_a, mul_b, mul_out;
  logic          out_valid, out_ready;
  logic [15:0]   out_data;
  logic [3:0]    out_flags;
  logic [CW-1:0] count;
  logic          busy, err;

  mul_issue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_out(mul_out), .mul_done(mul_done), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags), .count(count), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard: pairs pushed (in order), products returned by the stub (in order), results seen
  logic [31:0] pairs[$];
  int          pair_rd = 0;
  logic [15:0] exps[$];
  int          exp_rd = 0;
  logic [19:0] accs[$];

  int stub_lat   = 2;
  bit stub_rand  = 1'b0;
  bit stub_hang  = 1'b0;
  int spur_req   = 0;
  int spur_ack   = 0;
  int n_starts   = 0;
  int start_cyc  = 0;

  function automatic logic [3:0] ref_class(input logic [15:0] x);
    int e, f;
    bit nan, inf, zer, sub;
    e   = (int'(x) / 1024) % 32;
    f   = int'(x) % 1024;
    nan = (e == 31) && (f > 0);
    inf = (e == 31) && (f == 0);
    zer = (e == 0) && (f == 0);
    sub = (e == 0) && (f > 0);
    return {nan, inf, zer, sub};
  endfunction

  function automatic logic [15:0] rand_fp();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 3))
      0:       r[14:10] = 5'd0;
      1:       r[14:10] = 5'd31;
      default: r = r;
    endcase
    if ($urandom_range(0, 3) == 0) r[9:0] = 10'd0;
    return r;
  endfunction

  function automatic logic [15:0] product(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h3C00_4000: return 16'h4000;
      32'h7C00_0000: return 16'h7E00;
      32'h7BFF_7BFF: return 16'h7C00;
      32'h0400_3800: return 16'h0200;
      32'h8000_3C00: return 16'h8000;
      32'h3C00_3C00: return 16'h3C00;
      default:       return rand_fp();
    endcase
  endfunction

  // Multiplier stub: one operation at a time, configurable latency, optional hang
  initial begin : stub
    logic [15:0] cur_a, cur_b, res;
    logic [31:0] p;
    int          left;
    bit          pend;
    mul_done = 1'b0; mul_out = 16'h0000;
    cur_a = 16'h0; cur_b = 16'h0; res = 16'h0; left = 0; pend = 1'b0;
    forever begin
      @(posedge clk); #1;
      mul_done = 1'b0;
      if (rst) begin
        pend    = 1'b0;
        pair_rd = pairs.size();
      end else if (spur_req != spur_ack) begin
        spur_ack = spur_req;
        mul_done = 1'b1;
        mul_out  = 16'h1234;
      end else if (pend) begin
        check_val("start_while_busy", 32'(mul_start), 32'd0);
        check_val("mul_a_hold", 32'(mul_a), 32'(cur_a));
        check_val("mul_b_hold", 32'(mul_b), 32'(cur_b));
        if (left == 0) begin
          mul_done = 1'b1; mul_out = res; exps.push_back(res); pend = 1'b0;
        end else left--;
      end else if (mul_start) begin
        n_starts++;
        start_cyc = cyc;
        if (pair_rd >= pairs.size()) check_val("issue_without_push", 32'd1, 32'd0);
        else begin
          p = pairs[pair_rd];
          pair_rd++;
          check_val("mul_a", 32'(mul_a), 32'(p[31:16]));
          check_val("mul_b", 32'(mul_b), 32'(p[15:0]));
        end
        cur_a = mul_a; cur_b = mul_b; res = product(mul_a, mul_b);
        if (!stub_hang) begin
          left = stub_rand ? int'($urandom_range(0, 8)) : stub_lat;
          if (left == 0) begin
            mul_done = 1'b1; mul_out = res; exps.push_back(res);
          end else begin
            pend = 1'b1; left--;
          end
        end
      end
    end
  end

  // Output monitor: every accepted result must be the next product, correctly classified
  initial begin : out_mon
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst) exp_rd = exps.size();
      else if (out_valid && out_ready) begin
        if (exp_rd >= exps.size()) check_val("unexpected_result", 32'(out_data), 32'hFFFF_FFFF);
        else begin
          e = exps[exp_rd];
          exp_rd++;
          check_val("out_data", 32'(out_data), 32'(e));
          check_val("out_flags", 32'(out_flags), 32'(ref_class(e)));
        end
        accs.push_back({out_flags, out_data});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        pairs.push_back({a, b});
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      n++;
      if (n > 300) begin
        check_val("push_timeout", 32'(n), 32'd0);
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (!(count == '0 && !busy && !out_valid && !mul_start &&
             exp_rd == exps.size() && pair_rd == pairs.size())) begin
      @(posedge clk); #1;
      n++;
      if (n > budget) begin
        check_val("drain_timeout", 32'(n), 32'd0);
        return;
      end
    end
  endtask

  task automatic wait_out_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        check_val(tag, 32'(out_valid), 32'd1);
        return;
      end
    end
  endtask

  task automatic check_acc(input string tag, input int idx, input logic [19:0] expv);
    if (idx >= accs.size()) check_val(tag, 32'hDEAD_0000, 32'(expv));
    else check_val(tag, 32'(accs[idx]), 32'(expv));
  endtask

  initial begin : global_guard
    #2000000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin : main
    int base, a0, n, sent;
    bit acc;
    in_valid = 1'b0; in_a = 16'h0; in_b = 16'h0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_mul_start", 32'(mul_start), 32'd0);
    check_val("rst_out_data", 32'(out_data), 32'd0);
    check_val("rst_out_flags", 32'(out_flags), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single multiply 1.0 * 2.0
    out_ready = 1'b1; stub_lat = 3; base = n_starts; a0 = accs.size();
    push_pair(16'h3C00, 16'h4000);
    wait_drain(200);
    check_val("t1_starts", 32'(n_starts - base), 32'd1);
    check_acc("t1_result", a0, {4'b0000, 16'h4000});
    check_val("t1_count", 32'(count), 32'd0);

    // Backpressure: one issue, result held, FIFO fills
    out_ready = 1'b0; stub_lat = 2; a0 = accs.size();
    push_pair(16'h7C00, 16'h0000); @(negedge clk); check_val("t2_in_ready1", 32'(in_ready), 32'd1); @(posedge clk); #1;
    push_pair(16'h7BFF, 16'h7BFF); @(negedge clk); check_val("t2_in_ready2", 32'(in_ready), 32'd1); @(posedge clk); #1;
    push_pair(16'h0400, 16'h3800); @(negedge clk); check_val("t2_in_ready3", 32'(in_ready), 32'd1); @(posedge clk); #1;
    push_pair(16'h8000, 16'h3C00); @(negedge clk); check_val("t2_in_ready4", 32'(in_ready), 32'd1); @(posedge clk); #1;
    wait_out_valid("t2_first_valid");
    repeat (3) @(posedge clk); #1;
    check_val("t2_held_data", 32'(out_data), 32'h7E00);
    check_val("t2_held_flags", 32'(out_flags), 32'b1000);
    check_val("t2_count3", 32'(count), 32'd3);
    push_pair(16'h3C00, 16'h3C00);
    @(negedge clk);
    check_val("t2_count_full", 32'(count), 32'd4);
    check_val("t2_in_ready_full", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain(400);
    check_acc("t2_r0", a0,     {4'b1000, 16'h7E00});
    check_acc("t2_r1", a0 + 1, {4'b0100, 16'h7C00});
    check_acc("t2_r2", a0 + 2, {4'b0001, 16'h0200});
    check_acc("t2_r3", a0 + 3, {4'b0010, 16'h8000});
    check_acc("t2_r4", a0 + 4, {4'b0000, 16'h3C00});

    // Simultaneous push and pop with two entries queued
    out_ready = 1'b0; stub_lat = 2; a0 = accs.size();
    push_pair(16'h3C00, 16'h4000);
    push_pair(16'h7BFF, 16'h7BFF);
    push_pair(16'h0400, 16'h3800);
    wait_out_valid("t3_first_valid");
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_a = 16'h8000; in_b = 16'h3C00; in_valid = 1'b1;
    @(negedge clk);
    check_val("t3_pre_count", 32'(count), 32'd2);
    check_val("t3_pre_out_valid", 32'(out_valid), 32'd0);
    if (in_ready) pairs.push_back({in_a, in_b});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_val("t3_pushpop_count", 32'(count), 32'd2);
    check_val("t3_pushpop_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    wait_drain(400);
    check_acc("t3_r0", a0,     {4'b0000, 16'h4000});
    check_acc("t3_r1", a0 + 1, {4'b0100, 16'h7C00});
    check_acc("t3_r2", a0 + 2, {4'b0001, 16'h0200});
    check_acc("t3_r3", a0 + 3, {4'b0010, 16'h8000});

    // Watchdog: multiplier never answers
    out_ready = 1'b1; stub_hang = 1'b1; a0 = accs.size();
    push_pair(16'h3C00, 16'h3C00);
    n = 0;
    while (!err && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("t4_err_set", 32'(err), 32'd1);
    check_val("t4_err_latency", 32'(cyc - start_cyc), 32'(TIMEOUT));
    check_val("t4_busy_after", 32'(busy), 32'd0);
    check_val("t4_no_result", 32'(out_valid), 32'd0);
    stub_hang = 1'b0;
    push_pair(16'h0400, 16'h3800);
    wait_drain(200);
    check_acc("t4_next_result", a0, {4'b0001, 16'h0200});
    check_val("t4_err_sticky", 32'(err), 32'd1);

    // Reset while waiting with three entries queued
    stub_lat = 20;
    push_pair(16'h3C00, 16'h4000);
    push_pair(16'h7BFF, 16'h7BFF);
    push_pair(16'h0400, 16'h3800);
    push_pair(16'h8000, 16'h3C00);
    @(negedge clk);
    check_val("t5_pre_count", 32'(count), 32'd3);
    check_val("t5_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_val("t5_count", 32'(count), 32'd0);
    check_val("t5_out_valid", 32'(out_valid), 32'd0);
    check_val("t5_busy", 32'(busy), 32'd0);
    check_val("t5_err", 32'(err), 32'd0);
    check_val("t5_mul_start", 32'(mul_start), 32'd0);
    check_val("t5_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Spurious done while idle
    spur_req++;
    repeat (4) begin
      @(negedge clk);
      check_val("t6_out_valid", 32'(out_valid), 32'd0);
      check_val("t6_busy", 32'(busy), 32'd0);
    end
    @(posedge clk); #1;

    // Randomized traffic
    stub_rand = 1'b1; sent = 0; n = 0;
    while (sent < 60 && n < 5000) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) pairs.push_back({in_a, in_b});
      @(posedge clk); #1;
      n++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && sent < 60 && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        in_a = rand_fp();
        in_b = rand_fp();
      end
    end
    check_val("t7_all_sent", 32'(sent), 32'd60);
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain(3000);
    check_val("t7_err_clear", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
